// File: rtl/pipeline_pkg.sv
// Shared types and constants for the filter pipeline: pixel/word widths,
// the filter weight sum, and the loader FSM state encoding.
package pipeline_pkg;

  localparam int PIX_W      = 8;
  localparam int WORD_W     = 16;
  localparam int WEIGHT_SUM = 63;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    STALL
  } state_t;

  // pix * WEIGHT_SUM as shift-subtract; 255*63 = 16065 fits in WORD_W bits.
  function automatic logic [WORD_W-1:0] scale_pix(input logic [PIX_W-1:0] pix);
    logic [WORD_W-1:0] w;
    w = {{(WORD_W-PIX_W){1'b0}}, pix};
    return (w << 6) - w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and registered full/empty flags.
// Read data is the head entry; a word written this cycle is never bypassed to the read side.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
    rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      full   <= (count_nxt == CNT_FULL);
      empty  <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/input_pixel_loader.sv
// Pipeline front end: buffers pixels, scales by the weight sum (SCALE_EN) or passes them
// through zero-extended (SCALE_EN undefined), and emits them with valid/ready plus frame pulses.
module input_pixel_loader
  import pipeline_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PIX_W-1:0]  DataIn,
  input  logic              StartIn,
  output logic              Full,
  output logic [WORD_W-1:0] DataOut,
  output logic              StartOut,
  input  logic              ReadyIn,
  output logic              FrameDone,
  output logic              Overflow
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

  state_t            state_q, state_d;
  logic [PIX_W-1:0]  fifo_dat;
  logic              fifo_full, fifo_empty;
  logic              load, handshake;
  logic [WORD_W-1:0] scaled, data_q;
  logic [CW-1:0]     frame_cnt;
  logic              frame_done_q, overflow_q;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push   (StartIn),
    .wr_dat (DataIn),
    .pop    (load),
    .rd_dat (fifo_dat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

`ifdef SCALE_EN
  assign scaled = scale_pix(fifo_dat);
`else
  assign scaled = {{(WORD_W-PIX_W){1'b0}}, fifo_dat};
`endif

  assign handshake = (state_q != IDLE) && ReadyIn;
  assign load      = !fifo_empty && ((state_q == IDLE) || ReadyIn);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load) state_d = ACTIVE;
      end
      ACTIVE, STALL: begin
        if (!ReadyIn)  state_d = STALL;
        else if (load) state_d = ACTIVE;
        else           state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Output word clears to zero when the last word is taken with nothing behind it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= scaled;
    end else if (handshake) begin
      data_q <= '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (handshake) begin
        if (frame_cnt == CNT_LAST) begin
          frame_cnt    <= '0;
          frame_done_q <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      overflow_q <= 1'b0;
    else if (StartIn && fifo_full)  overflow_q <= 1'b1;
  end

  assign Full      = fifo_full;
  assign DataOut   = data_q;
  assign StartOut  = (state_q != IDLE);
  assign FrameDone = frame_done_q;
  assign Overflow  = overflow_q;

endmodule

// File: tb/tb_input_pixel_loader.sv
// Scoreboard bench for input_pixel_loader: expected words queued at push, checked at each handshake.
module tb_input_pixel_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  DataIn = '0;
  logic        StartIn = 1'b0;
  logic        ReadyIn = 1'b0;
  logic        Full, StartOut, FrameDone, Overflow;
  logic [15:0] DataOut;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] sb [$];
  logic        stall_prev = 1'b0;
  logic [15:0] held = '0;

  input_pixel_loader #(.DEPTH(8), .FRAME_LEN(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .DataIn    (DataIn),
    .StartIn   (StartIn),
    .Full      (Full),
    .DataOut   (DataOut),
    .StartOut  (StartOut),
    .ReadyIn   (ReadyIn),
    .FrameDone (FrameDone),
    .Overflow  (Overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] model(input logic [7:0] p);
`ifdef SCALE_EN
    return 16'(p) * 16'd63;
`else
    return {8'h00, p};
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    StartIn = 1'b0;
    ReadyIn = 1'b0;
    DataIn = '0;
    sb.delete();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // Inputs settle 1 unit after posedge, so the negedge sees what the next posedge will see.
  always @(negedge clock) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        n_tests++;
        if (StartOut !== 1'b1 || DataOut !== held) begin
          n_fail++;
          $display("FAIL stall_hold: StartOut=%b DataOut=%h, required StartOut=1 DataOut=%h", StartOut, DataOut, held);
        end
      end
      if (StartOut === 1'b1 && ReadyIn === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: DataOut=%h, required no word", DataOut);
        end else begin
          logic [15:0] exp_w;
          exp_w = sb.pop_front();
          if (DataOut !== exp_w) begin
            n_fail++;
            $display("FAIL word_order: DataOut=%h, required %h", DataOut, exp_w);
          end
        end
      end
      stall_prev = (StartOut === 1'b1) && (ReadyIn === 1'b0);
      held = DataOut;
    end
  end

  task automatic drain(input string name);
    for (int c = 0; c < 200 && sb.size() > 0; c++) tick();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d words outstanding, required 0", name, sb.size());
    end
    tick();
    n_tests++;
    if (StartOut !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: StartOut=%b, required 0", name, StartOut);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_tests++; if (Full      !== 1'b0)  begin n_fail++; $display("FAIL reset_full: %b, required 0", Full); end
    n_tests++; if (StartOut  !== 1'b0)  begin n_fail++; $display("FAIL reset_startout: %b, required 0", StartOut); end
    n_tests++; if (DataOut   !== 16'h0) begin n_fail++; $display("FAIL reset_dataout: %h, required 0000", DataOut); end
    n_tests++; if (FrameDone !== 1'b0)  begin n_fail++; $display("FAIL reset_framedone: %b, required 0", FrameDone); end
    n_tests++; if (Overflow  !== 1'b0)  begin n_fail++; $display("FAIL reset_overflow: %b, required 0", Overflow); end
    reset = 1'b0;
    tick();
  endtask

  task automatic single_word(input string name, input logic [7:0] pix, input logic [15:0] want);
    ReadyIn = 1'b1;
    DataIn = pix;
    StartIn = 1'b1;
    sb.push_back(model(pix));
    tick();
    StartIn = 1'b0;
    n_tests++; if (StartOut !== 1'b0) begin n_fail++; $display("FAIL %s_no_bypass: StartOut=%b, required 0", name, StartOut); end
    tick();
    n_tests++; if (StartOut !== 1'b1) begin n_fail++; $display("FAIL %s_valid: StartOut=%b, required 1", name, StartOut); end
    n_tests++; if (DataOut !== want)  begin n_fail++; $display("FAIL %s_value: DataOut=%0d, required %0d", name, DataOut, want); end
    tick();
    n_tests++; if (StartOut !== 1'b0) begin n_fail++; $display("FAIL %s_release: StartOut=%b, required 0", name, StartOut); end
    n_tests++; if (DataOut !== 16'h0) begin n_fail++; $display("FAIL %s_clear: DataOut=%h, required 0000", name, DataOut); end
  endtask

  task automatic test_single();
`ifdef SCALE_EN
    single_word("max_pixel", 8'd255, 16'd16065);
`else
    single_word("max_pixel", 8'd255, 16'd255);
`endif
  endtask

  task automatic test_passthrough();
`ifdef SCALE_EN
    single_word("pix200", 8'd200, 16'd12600);
`else
    single_word("pix200", 8'd200, 16'd200);
`endif
  endtask

  task automatic test_fill_overflow();
    ReadyIn = 1'b0;
    // First accepted pixel moves into the output register, so the FIFO fills on the 9th.
    for (int i = 0; i < 9; i++) begin
      DataIn = 8'(8'h10 + i);
      StartIn = 1'b1;
      sb.push_back(model(DataIn));
      tick();
      if (i == 7) begin
        n_tests++; if (Full !== 1'b0) begin n_fail++; $display("FAIL fill_full_early: Full=%b, required 0", Full); end
      end
    end
    n_tests++; if (Full !== 1'b1)     begin n_fail++; $display("FAIL fill_full: Full=%b, required 1", Full); end
    n_tests++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovf: Overflow=%b, required 0", Overflow); end
    DataIn = 8'hEE;
    tick();
    n_tests++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: Overflow=%b, required 1", Overflow); end
    DataIn = 8'hDD;
    ReadyIn = 1'b1;
    tick();
    StartIn = 1'b0;
    n_tests++; if (Full !== 1'b0)     begin n_fail++; $display("FAIL pop_refused_push: Full=%b, required 0", Full); end
    drain("fill");
    n_tests++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: Overflow=%b, required 1", Overflow); end
  endtask

  task automatic test_stall_order();
    int pushed;
    pushed = 0;
    for (int cyc = 0; cyc < 300 && pushed < 20; cyc++) begin
      ReadyIn = cyc[0];
      if (!Full) begin
        StartIn = 1'b1;
        DataIn = 8'($urandom_range(0, 255));
        sb.push_back(model(DataIn));
        pushed++;
      end else begin
        StartIn = 1'b0;
      end
      tick();
    end
    StartIn = 1'b0;
    n_tests++; if (pushed != 20) begin n_fail++; $display("FAIL stall_pushed: %0d pixels, required 20", pushed); end
    ReadyIn = 1'b1;
    drain("stall");
  endtask

  task automatic test_mid_reset();
    ReadyIn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      DataIn = 8'(8'hA0 + i);
      StartIn = 1'b1;
      sb.push_back(model(DataIn));
      tick();
    end
    StartIn = 1'b0;
    n_tests++; if (StartOut !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: StartOut=%b, required 1", StartOut); end
    n_tests++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_ovf: Overflow=%b, required 1", Overflow); end
    reset = 1'b1;
    sb.delete();
    #1;
    n_tests++; if (Full      !== 1'b0)  begin n_fail++; $display("FAIL midrst_full: %b, required 0", Full); end
    n_tests++; if (StartOut  !== 1'b0)  begin n_fail++; $display("FAIL midrst_startout: %b, required 0", StartOut); end
    n_tests++; if (DataOut   !== 16'h0) begin n_fail++; $display("FAIL midrst_dataout: %h, required 0000", DataOut); end
    n_tests++; if (FrameDone !== 1'b0)  begin n_fail++; $display("FAIL midrst_framedone: %b, required 0", FrameDone); end
    n_tests++; if (Overflow  !== 1'b0)  begin n_fail++; $display("FAIL midrst_overflow: %b, required 0", Overflow); end
    tick();
    reset = 1'b0;
    ReadyIn = 1'b1;
    repeat (10) tick();
    n_tests++; if (StartOut !== 1'b0) begin n_fail++; $display("FAIL midrst_stale: StartOut=%b, required 0", StartOut); end
    DataIn = 8'h5A;
    StartIn = 1'b1;
    sb.push_back(model(DataIn));
    tick();
    StartIn = 1'b0;
    drain("midrst");
  endtask

  task automatic test_frame();
    int pulses;
    apply_reset();
    ReadyIn = 1'b1;
    pulses = 0;
    // Pixel c is pushed at edge c and handed over at edge c+2: handshakes 64 and 128 land on edges 66 and 130.
    for (int c = 1; c <= 135; c++) begin
      if (c <= 128) begin
        StartIn = 1'b1;
        DataIn = 8'(c);
        sb.push_back(model(DataIn));
      end else begin
        StartIn = 1'b0;
      end
      tick();
      if (FrameDone === 1'b1) pulses++;
      n_tests++;
      if (FrameDone !== ((c == 66) || (c == 130))) begin
        n_fail++;
        $display("FAIL frame_done_edge%0d: FrameDone=%b, required %b", c, FrameDone, (c == 66) || (c == 130));
      end
    end
    n_tests++; if (pulses != 2) begin n_fail++; $display("FAIL frame_pulses: %0d pulses, required 2", pulses); end
    drain("frame");
  endtask

  initial begin
    test_reset();
    test_single();
    test_passthrough();
    test_fill_overflow();
    test_stall_order();
    test_mid_reset();
    test_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
